// File: rtl/dco_lin_pkg.sv
// rtl/dco_lin_pkg.sv - shared widths, types and increment calculation for the linear DCO
// Purpose: default code/phase widths, code_t/phase_t typedefs, and inc_calc,
//          which forms F0_INC + GAIN*code at a wide width and clamps it to
//          half the accumulator range (f_clk/2 ceiling).
// Ports:   none (package)
package dco_lin_pkg;

    localparam int unsigned CODE_W_DEF = 13;
    localparam int unsigned ACC_W_DEF  = 16;
    // Wide enough for ACC_W+9 bits at any practical accumulator width.
    localparam int unsigned CALC_W     = 40;

    typedef logic [CODE_W_DEF-1:0] code_t;
    typedef logic [ACC_W_DEF-1:0]  phase_t;

    function automatic logic [CALC_W-1:0] inc_calc(
        input logic [CALC_W-1:0] f0,
        input logic [CALC_W-1:0] gain,
        input logic [CALC_W-1:0] code,
        input int unsigned       acc_w
    );
        logic [CALC_W-1:0] sum;
        logic [CALC_W-1:0] lim;
        sum = f0 + gain * code;
        lim = CALC_W'(1) << (acc_w - 1);
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/dco_lin_nco_if.sv
// rtl/dco_lin_nco_if.sv - control/observation bundle of the linear DCO
// Purpose: groups the DCO control inputs and its outputs.
// Signals: en (accumulator enable), code (frequency word), out (square wave),
//          phase (accumulator), freq_cnt/freq_vld (frequency meter result).
// Modports: master = controller/observer side, slave = DCO side.
interface dco_lin_nco_if
    import dco_lin_pkg::*;
#(
    parameter int unsigned CODE_W = CODE_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
);
    logic              en;
    logic [CODE_W-1:0] code;
    logic              out;
    logic [ACC_W-1:0]  phase;
    logic [15:0]       freq_cnt;
    logic              freq_vld;

    modport master (output en, code, input out, phase, freq_cnt, freq_vld);
    modport slave  (input en, code, output out, phase, freq_cnt, freq_vld);
endinterface

// File: rtl/dco_freq_meter.sv
// rtl/dco_freq_meter.sv - gated rising-edge counter for DCO characterisation
// Purpose: counts rising edges of sig over a WIN_CYC-cycle window, publishes
//          the count on freq_cnt with a one-cycle freq_vld pulse.
// Ports:   clk, rst_n (async active-low), sig (signal under test),
//          freq_cnt (16-bit saturated edge count), freq_vld (update pulse).
module dco_freq_meter #(
    parameter int unsigned WIN_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig,
    output logic [15:0] freq_cnt,
    output logic        freq_vld
);
    localparam int unsigned      WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

    logic             sig_d;
    logic             rise;
    logic [WIN_W-1:0] win_cnt;
    logic [15:0]      edge_cnt;
    logic [15:0]      edge_sum;

    assign rise     = sig & ~sig_d;
    // Count including the current cycle's edge, sticking at all-ones.
    assign edge_sum = (rise && (edge_cnt != 16'hFFFF)) ? edge_cnt + 16'd1 : edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_d    <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            freq_cnt <= '0;
            freq_vld <= 1'b0;
        end else begin
            sig_d <= sig;
            if (win_cnt == WIN_LAST) begin
                win_cnt  <= '0;
                freq_cnt <= edge_sum;
                freq_vld <= 1'b1;
                edge_cnt <= '0;
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                freq_vld <= 1'b0;
                edge_cnt <= edge_sum;
            end
        end
    end
endmodule

// File: rtl/dco_lin_nco.sv
// rtl/dco_lin_nco.sv - linear digitally-controlled oscillator (phase-accumulator NCO)
// Purpose: f_out = f_clk * min(F0_INC + GAIN*code, 2^(ACC_W-1)) / 2^ACC_W.
//          Pipeline: code_q -> inc_q -> acc -> out; code changes are
//          phase-continuous and take effect on the 3rd edge.
// Ports:   clk, rst_n (async active-low), dco (dco_lin_nco_if.slave:
//          en, code in; out, phase, freq_cnt, freq_vld out).
// Option:  DCO_FREQ_METER_EN adds the frequency meter; otherwise
//          freq_cnt/freq_vld are tied to 0.
module dco_lin_nco
    import dco_lin_pkg::*;
#(
    parameter int unsigned CODE_W  = CODE_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned F0_INC  = 0,
    parameter int unsigned GAIN    = 1,
    parameter int unsigned WIN_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    dco_lin_nco_if.slave  dco
);
    logic [CODE_W-1:0] code_q;
    logic [ACC_W-1:0]  inc_q;
    logic [ACC_W-1:0]  acc;
    logic              out_q;

    if (WIN_CYC < 1) begin : g_bad_win
        $error("WIN_CYC must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            inc_q  <= '0;
            acc    <= '0;
            out_q  <= 1'b0;
        end else begin
            code_q <= dco.code;
            // Clamped result never exceeds 2^(ACC_W-1), so the cast is lossless.
            inc_q  <= ACC_W'(inc_calc(CALC_W'(F0_INC), CALC_W'(GAIN),
                                      CALC_W'(code_q), ACC_W));
            if (dco.en) begin
                acc <= acc + inc_q;
            end
            out_q  <= acc[ACC_W-1];
        end
    end

    assign dco.out   = out_q;
    assign dco.phase = acc;

`ifdef DCO_FREQ_METER_EN
    dco_freq_meter #(
        .WIN_CYC (WIN_CYC)
    ) u_meter (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig      (out_q),
        .freq_cnt (dco.freq_cnt),
        .freq_vld (dco.freq_vld)
    );
`else
    assign dco.freq_cnt = '0;
    assign dco.freq_vld = 1'b0;
`endif
endmodule

// File: tb/tb_dco_lin_nco.sv
// tb/tb_dco_lin_nco.sv - directed self-checking bench for dco_lin_nco
module tb_dco_lin_nco;
    import dco_lin_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dco_lin_nco_if #(.CODE_W(13), .ACC_W(16)) b0 ();
    dco_lin_nco_if #(.CODE_W(14), .ACC_W(16)) b1 ();
    dco_lin_nco_if #(.CODE_W(13), .ACC_W(16)) b2 ();

    dco_lin_nco dut0 (.clk(clk), .rst_n(rst_n), .dco(b0));
    dco_lin_nco #(.CODE_W(14)) dut1 (.clk(clk), .rst_n(rst_n), .dco(b1));
    dco_lin_nco #(.GAIN(16)) dut2 (.clk(clk), .rst_n(rst_n), .dco(b2));

    // Reset all DUTs with the given codes applied; release on a falling edge.
    task automatic start(input logic [12:0] c0, input logic [13:0] c1, input logic [12:0] c2);
        rst_n   = 1'b0;
        b0.en   = 1'b1;
        b1.en   = 1'b1;
        b2.en   = 1'b1;
        b0.code = c0;
        b1.code = c1;
        b2.code = c2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (b0.freq_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        b0.en   = 1'b1;
        b0.code = 13'd4096;
        repeat (2) @(negedge clk);
        n_chk++; if (b0.phase !== 16'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", b0.phase); end
        n_chk++; if (b0.out !== 1'b0) begin n_fail++; $display("FAIL reset_out got %b want 0", b0.out); end
        n_chk++; if (b0.freq_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_freq_cnt got %0d want 0", b0.freq_cnt); end
        n_chk++; if (b0.freq_vld !== 1'b0) begin n_fail++; $display("FAIL reset_freq_vld got %b want 0", b0.freq_vld); end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        int hi, lo, w;
        bit ok;
        start(13'd4096, 14'd0, 13'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            e = (k >= 3) ? 16'((k - 2) * 4096) : 16'd0;
            n_chk++; if (b0.phase !== e) begin n_fail++; $display("FAIL basic_phase k=%0d got %0d want %0d", k, b0.phase, e); end
        end
        w = 0;
        while (!(b0.out === 1'b1) && w < 40) begin w++; @(negedge clk); end
        while (b0.out === 1'b1 && w < 40) begin w++; @(negedge clk); end
        while (b0.out === 1'b0 && w < 80) begin w++; @(negedge clk); end
        hi = 0;
        while (b0.out === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
        lo = 0;
        while (b0.out === 1'b0 && lo < 40) begin lo++; @(negedge clk); end
        n_chk++; if (hi != 8) begin n_fail++; $display("FAIL basic_high_cycles got %0d want 8", hi); end
        n_chk++; if (lo != 8) begin n_fail++; $display("FAIL basic_low_cycles got %0d want 8", lo); end
`ifdef DCO_FREQ_METER_EN
        wait_vld(ok);
        wait_vld(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_vld_timeout got 0 want 1"); end
        n_chk++; if (b0.freq_cnt !== 16'd64) begin n_fail++; $display("FAIL basic_freq_cnt got %0d want 64", b0.freq_cnt); end
        @(negedge clk);
        n_chk++; if (b0.freq_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_pulse got %b want 0", b0.freq_vld); end
`else
        ok = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (b0.freq_cnt !== 16'd0 || b0.freq_vld !== 1'b0) ok = 1'b0;
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_meter_tied got nonzero want 0"); end
`endif
    endtask

    task automatic test_code_zero();
        int bad_out, bad_ph;
        bit ok;
        start(13'd0, 14'd0, 13'd0);
        bad_out = 0;
        bad_ph  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b0.out !== 1'b0) bad_out++;
            if (b0.phase !== 16'd0) bad_ph++;
        end
        n_chk++; if (bad_out != 0) begin n_fail++; $display("FAIL zero_out got %0d high cycles want 0", bad_out); end
        n_chk++; if (bad_ph != 0) begin n_fail++; $display("FAIL zero_phase got %0d nonzero cycles want 0", bad_ph); end
`ifdef DCO_FREQ_METER_EN
        wait_vld(ok);
        n_chk++; if (!ok || b0.freq_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_freq_cnt got %0d (vld %b) want 0", b0.freq_cnt, ok); end
`endif
    endtask

    task automatic test_ramp();
        logic [15:0] p0;
        logic [15:0] d;
`ifdef DCO_FREQ_METER_EN
        logic [15:0] prev;
        bit ok;
        prev = 16'd0;
`endif
        start(13'd0, 14'd0, 13'd0);
        for (int c = 0; c < 8192; c++) begin
            b0.code = 13'(c);
            @(negedge clk);
`ifdef DCO_FREQ_METER_EN
            if (b0.freq_vld === 1'b1) begin
                n_chk++; if (b0.freq_cnt < prev) begin n_fail++; $display("FAIL ramp_monotonic got %0d want >= %0d", b0.freq_cnt, prev); end
                prev = b0.freq_cnt;
            end
`endif
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            p0 = b0.phase;
            @(negedge clk);
            d = b0.phase - p0;
            n_chk++; if (d !== 16'd8191) begin n_fail++; $display("FAIL ramp_top_step got %0d want 8191", d); end
        end
`ifdef DCO_FREQ_METER_EN
        wait_vld(ok);
        wait_vld(ok);
        n_chk++; if (!ok || b0.freq_cnt < 16'd127 || b0.freq_cnt > 16'd128) begin n_fail++; $display("FAIL ramp_top_freq got %0d want 127..128", b0.freq_cnt); end
`endif
    endtask

    task automatic test_step();
        logic [15:0] e;
        start(13'd0, 14'd4096, 13'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            case (k)
                5:       e = 16'd12288;
                6:       e = 16'd16384;
                7:       e = 16'd20480;
                8:       e = 16'd28672;
                9:       e = 16'd36864;
                default: e = (k >= 3) ? 16'((k - 2) * 4096) : 16'd0;
            endcase
            n_chk++; if (b1.phase !== e) begin n_fail++; $display("FAIL step_phase k=%0d got %0d want %0d", k, b1.phase, e); end
            if (k == 5) b1.code = 14'd8192;
        end
    endtask

    task automatic test_clamp();
        logic [15:0] e;
        logic        eo;
        start(13'd0, 14'd0, 13'd4096);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                e = (k % 2 == 1) ? 16'd32768 : 16'd0;
                n_chk++; if (b2.phase !== e) begin n_fail++; $display("FAIL clamp_phase k=%0d got %0d want %0d", k, b2.phase, e); end
            end
            if (k >= 4) begin
                eo = (k % 2 == 0);
                n_chk++; if (b2.out !== eo) begin n_fail++; $display("FAIL clamp_out k=%0d got %b want %b", k, b2.out, eo); end
            end
        end
    endtask

    task automatic test_enable();
        int bad;
        start(13'd4096, 14'd0, 13'd0);
        repeat (11) @(negedge clk);
        n_chk++; if (b0.phase !== 16'd36864) begin n_fail++; $display("FAIL en_pre_phase got %0d want 36864", b0.phase); end
        b0.en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b0.phase !== 16'd36864 || b0.out !== 1'b1) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL en_frozen got %0d moving cycles want 0", bad); end
        b0.en = 1'b1;
        @(negedge clk);
        n_chk++; if (b0.phase !== 16'd40960) begin n_fail++; $display("FAIL en_resume got %0d want 40960", b0.phase); end
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        start(13'd4096, 14'd0, 13'd0);
        repeat (11) @(negedge clk);
        n_chk++; if (b0.out !== 1'b1) begin n_fail++; $display("FAIL arst_pre_out got %b want 1", b0.out); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (b0.phase !== 16'd0) begin n_fail++; $display("FAIL arst_phase got %0d want 0", b0.phase); end
        n_chk++; if (b0.out !== 1'b0) begin n_fail++; $display("FAIL arst_out got %b want 0", b0.out); end
        n_chk++; if (b0.freq_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_freq_cnt got %0d want 0", b0.freq_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e = (k >= 3) ? 16'((k - 2) * 4096) : 16'd0;
            n_chk++; if (b0.phase !== e) begin n_fail++; $display("FAIL arst_restart k=%0d got %0d want %0d", k, b0.phase, e); end
        end
    endtask

    initial begin
        b0.en = 1'b0; b0.code = '0;
        b1.en = 1'b0; b1.code = '0;
        b2.en = 1'b0; b2.code = '0;
        test_reset();
        test_basic();
        test_code_zero();
        test_ramp();
        test_step();
        test_clamp();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
